tdc_edge_decoder: RTL and testbench

TDC_EDGE_DECODER -- requirements
Module: tdc_edge_decoder

---
 rtl/tdc_edge_decoder.sv | 90 +++++++++
 tb/tb_tdc_edge_decoder.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/tdc_edge_decoder.sv
// tdc_edge_decoder: snapshots a thermometer-coded delay line on go and decodes the
// qualifying edge position, qualifying-edge count and bubble flag.
module tdc_edge_decoder #(
    parameter int NUM_TAPS      = 36,
    parameter int NUM_DECODE    = 8,
    parameter int RUN_LEN       = 4,
    parameter int FALLING       = 0,
    parameter int PRIORITY_LAST = 1,
    parameter int CNT_W         = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  go,
    input  logic [NUM_TAPS-1:0]   taps_in,
    output logic                  busy,
    output logic                  done,
    output logic [NUM_DECODE-1:0] code_out,
    output logic                  edge_found,
    output logic [CNT_W-1:0]      edge_count,
    output logic                  multi_edge,
    output logic                  go_dropped
);
    localparam int NC   = NUM_TAPS - RUN_LEN;
    localparam int CW   = $clog2(NC + 1);
    localparam int MAXC = 2 ** CNT_W - 1;

    typedef enum logic [1:0] {IDLE, DECODE, DONE} state_t;

    state_t                  state;
    logic [NUM_TAPS-1:0]     snap;
    logic [NC-1:0]           qual;
    logic [CW-1:0]           cnt;
    logic [NUM_DECODE-1:0]   win;

    for (genvar i = 0; i < NC; i++) begin : g_qual
        assign qual[i] = (FALLING != 0) ? (!snap[i] && (&snap[i+1 +: RUN_LEN]))
                                        : (snap[i] && !(|snap[i+1 +: RUN_LEN]));
    end

    // Ascending scan: the last hit overwrites for PRIORITY_LAST, otherwise the first hit sticks.
    always_comb begin
        cnt = '0;
        win = '0;
        for (int j = 0; j < NC; j++) begin
            if (qual[j]) begin
                cnt = cnt + CW'(1);
                if (PRIORITY_LAST != 0 || win == '0) win = NUM_DECODE'(j + 1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            snap       <= '0;
            code_out   <= '0;
            edge_found <= 1'b0;
            edge_count <= '0;
            multi_edge <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            go_dropped <= 1'b0;
        end else begin
            go_dropped <= go && state != IDLE;
            done       <= 1'b0;
            case (state)
                IDLE: begin
                    if (go) begin
                        snap  <= taps_in;
                        state <= DECODE;
                        busy  <= 1'b1;
                    end
                end
                DECODE: begin
                    code_out   <= win;
                    edge_found <= cnt != '0;
                    edge_count <= (32'(cnt) > MAXC) ? CNT_W'(MAXC) : CNT_W'(cnt);
                    multi_edge <= 32'(cnt) > 1;
                    done       <= 1'b1;
                    state      <= DONE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tdc_edge_decoder.sv
// tb_tdc_edge_decoder: four parameter variants share stimulus; expected results are
// queued per variant and popped by a monitor whenever the variant pulses done.
module tb_tdc_edge_decoder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        go = 1'b0;
    logic [35:0] taps = '0;

    logic       busy_a, done_a, found_a, multi_a, drop_a;
    logic [7:0] code_a;
    logic [2:0] cnt_a;
    logic       busy_b, done_b, found_b, multi_b, drop_b;
    logic [7:0] code_b;
    logic [2:0] cnt_b;
    logic       busy_c, done_c, found_c, multi_c, drop_c;
    logic [7:0] code_c;
    logic [2:0] cnt_c;
    logic       busy_d, done_d, found_d, multi_d, drop_d;
    logic [7:0] code_d;
    logic [1:0] cnt_d;

    typedef struct {
        logic [7:0] code;
        logic       found;
        logic [2:0] cnt;
        logic       multi;
    } exp_t;

    exp_t qa[$], qb[$], qc[$], qd[$];
    int checks = 0;
    int fails = 0;

    always #5 clk = ~clk;

    tdc_edge_decoder u_a (
        .clk(clk), .rst(rst), .go(go), .taps_in(taps), .busy(busy_a), .done(done_a),
        .code_out(code_a), .edge_found(found_a), .edge_count(cnt_a),
        .multi_edge(multi_a), .go_dropped(drop_a));

    tdc_edge_decoder #(.FALLING(1)) u_b (
        .clk(clk), .rst(rst), .go(go), .taps_in(taps), .busy(busy_b), .done(done_b),
        .code_out(code_b), .edge_found(found_b), .edge_count(cnt_b),
        .multi_edge(multi_b), .go_dropped(drop_b));

    tdc_edge_decoder #(.PRIORITY_LAST(0)) u_c (
        .clk(clk), .rst(rst), .go(go), .taps_in(taps), .busy(busy_c), .done(done_c),
        .code_out(code_c), .edge_found(found_c), .edge_count(cnt_c),
        .multi_edge(multi_c), .go_dropped(drop_c));

    tdc_edge_decoder #(.CNT_W(2)) u_d (
        .clk(clk), .rst(rst), .go(go), .taps_in(taps), .busy(busy_d), .done(done_d),
        .code_out(code_d), .edge_found(found_d), .edge_count(cnt_d),
        .multi_edge(multi_d), .go_dropped(drop_d));

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (done_a) begin
            if (qa.size() == 0) cmp("a_unexpected_done", 1, 0);
            else begin
                e = qa.pop_front();
                cmp("a_result", {code_a, found_a, cnt_a, multi_a}, {e.code, e.found, e.cnt, e.multi});
            end
        end
        if (done_b) begin
            if (qb.size() == 0) cmp("b_unexpected_done", 1, 0);
            else begin
                e = qb.pop_front();
                cmp("b_falling_result", {code_b, found_b, cnt_b, multi_b}, {e.code, e.found, e.cnt, e.multi});
            end
        end
        if (done_c) begin
            if (qc.size() == 0) cmp("c_unexpected_done", 1, 0);
            else begin
                e = qc.pop_front();
                cmp("c_first_result", {code_c, found_c, cnt_c, multi_c}, {e.code, e.found, e.cnt, e.multi});
            end
        end
        if (done_d) begin
            if (qd.size() == 0) cmp("d_unexpected_done", 1, 0);
            else begin
                e = qd.pop_front();
                cmp("d_sat_result", {code_d, found_d, 1'b0, cnt_d, multi_d}, {e.code, e.found, e.cnt, e.multi});
            end
        end
    end

    task automatic expect_all(input logic [7:0] a_code, input logic [2:0] a_cnt, input logic [7:0] c_code,
                              input logic [7:0] b_code, input logic [2:0] b_cnt, input logic [2:0] d_cnt);
        qa.push_back('{a_code, a_cnt != 0, a_cnt, a_cnt > 1});
        qc.push_back('{c_code, a_cnt != 0, a_cnt, a_cnt > 1});
        qb.push_back('{b_code, b_cnt != 0, b_cnt, b_cnt > 1});
        qd.push_back('{a_code, a_cnt != 0, d_cnt, a_cnt > 1});
    endtask

    // Taps are scrambled right after the go edge, so every conversion also checks snapshot isolation.
    task automatic conv(input logic [35:0] t, input logic [7:0] a_code, input logic [2:0] a_cnt,
                        input logic [7:0] c_code, input logic [7:0] b_code, input logic [2:0] b_cnt,
                        input logic [2:0] d_cnt);
        expect_all(a_code, a_cnt, c_code, b_code, b_cnt, d_cnt);
        taps = t;
        go = 1'b1;
        @(posedge clk);
        #1 go = 1'b0;
        taps = ~t;
        cmp("busy_after_go", {31'b0, busy_a}, 1);
        @(negedge clk);
        cmp("no_early_done", {31'b0, done_a}, 0);
        @(posedge clk);
        @(negedge clk);
        cmp("done_latency", {31'b0, done_a}, 1);
        @(posedge clk);
        #1 cmp("busy_clear_idle", {31'b0, busy_a}, 0);
    endtask

    initial begin
        int drops;
        #1 cmp("reset_outputs", {code_a, found_a, cnt_a, multi_a, busy_a, done_a, drop_a}, 0);
        @(negedge clk);
        rst = 1'b0;
        conv(36'h0_0000_00FF,  8, 1,  8,  0, 0, 1);
        conv(36'hF_FFFF_FF00,  0, 0,  0,  8, 1, 0);
        conv(36'hF_FFFF_FFFF,  0, 0,  0,  0, 0, 0);
        conv(36'h0_0000_F0FF, 16, 2,  8, 12, 1, 2);
        conv(36'h0_0000_0FFF, 12, 1, 12,  0, 0, 1);
        conv(36'h0_0000_0000,  0, 0,  0,  0, 0, 0);
        conv(36'h0_4210_8421, 31, 7,  1,  0, 0, 3);
        conv(36'h0_8000_0000, 32, 1, 32,  0, 0, 1);
        conv(36'hF_0000_0000,  0, 0,  0, 32, 1, 0);
        // go held for four edges: accepted, dropped twice while busy, accepted again on IDLE
        expect_all(8, 1, 8, 0, 0, 1);
        expect_all(8, 1, 8, 0, 0, 1);
        taps = 36'h0_0000_00FF;
        go = 1'b1;
        drops = 0;
        @(posedge clk);
        repeat (3) begin
            @(negedge clk);
            drops += int'(drop_a);
            @(posedge clk);
        end
        #1 go = 1'b0;
        repeat (4) begin
            @(negedge clk);
            drops += int'(drop_a);
        end
        cmp("go_dropped_pulses", drops, 2);
        cmp("queue_drained_held", qa.size(), 0);
        // asynchronous reset in the middle of DECODE
        taps = 36'h0_0000_00FF;
        @(negedge clk);
        go = 1'b1;
        @(posedge clk);
        #1 go = 1'b0;
        #2 rst = 1'b1;
        #1 cmp("async_reset_outputs", {code_a, found_a, cnt_a, multi_a, busy_a, done_a, drop_a}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        conv(36'h0_0000_F0FF, 16, 2,  8, 12, 1, 2);
        conv(36'h0_0000_00FF,  8, 1,  8,  0, 0, 1);
        repeat (3) @(negedge clk);
        cmp("queues_drained", qa.size() + qb.size() + qc.size() + qd.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
